// File: rtl/mac_requant.sv
// Requantizer: ReLU, unsigned scale multiply, shift, zero-point add, int8 saturate; 3-stage AXIS pipeline.
// Build option: define REQUANT_ROUND_EN for a round-half-up shift instead of the default floor shift.
module mac_requant #(
  parameter int C_ACC_WIDTH   = 32,
  parameter int C_SCALE_WIDTH = 16,
  parameter int C_OUT_WIDTH   = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [C_SCALE_WIDTH-1:0] CFG_SCALE,
  input  logic [4:0]               CFG_SHIFT,
  input  logic [C_OUT_WIDTH-1:0]   CFG_ZERO_POINT,
  input  logic                     CFG_RELU,
  input  logic [C_ACC_WIDTH-1:0]   SD_AXIS_TDATA,
  input  logic                     SD_AXIS_TVALID,
  input  logic                     SD_AXIS_TLAST,
  input  logic [7:0]               SD_AXIS_TID,
  output logic                     SD_AXIS_TREADY,
  output logic [C_OUT_WIDTH-1:0]   MO_AXIS_TDATA,
  output logic                     MO_AXIS_TVALID,
  input  logic                     MO_AXIS_TREADY,
  output logic                     MO_AXIS_TLAST,
  output logic [7:0]               MO_AXIS_TID
);

  localparam int NS = 3;
  localparam int PW = C_ACC_WIDTH + C_SCALE_WIDTH + 1;
  localparam int RW = PW + 1;
  localparam logic signed [RW:0] SAT_MAX = (RW + 1)'(2 ** (C_OUT_WIDTH - 1) - 1);
  localparam logic signed [RW:0] SAT_MIN = -SAT_MAX - 1;

  logic                         en;
  logic [NS-1:0]                valid_reg;
  logic [NS-1:0]                valid_next;
  logic [NS-1:0]                last_reg;
  logic [NS-1:0]                last_next;
  logic [7:0]                   id_reg  [NS];
  logic [7:0]                   id_next [NS];

  logic signed [C_ACC_WIDTH-1:0] relu_reg;
  logic signed [C_ACC_WIDTH-1:0] relu_next;
  logic signed [PW-1:0]          prod_reg;
  logic signed [PW-1:0]          prod_next;
  logic signed [RW-1:0]          round_bias;
  logic signed [RW-1:0]          biased;
  logic signed [RW-1:0]          shifted;
  logic signed [RW:0]            summed;
  logic [C_OUT_WIDTH-1:0]        out_reg;
  logic [C_OUT_WIDTH-1:0]        out_next;

  // One shared enable: the whole pipeline stalls as a unit when the output is blocked.
  assign en             = !valid_reg[NS-1] || MO_AXIS_TREADY;
  assign SD_AXIS_TREADY = ARESETN && en;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_side
      if (gi == 0) begin : g_head
        assign valid_next[gi] = SD_AXIS_TVALID;
        assign last_next[gi]  = SD_AXIS_TLAST;
        assign id_next[gi]    = SD_AXIS_TID;
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign last_next[gi]  = last_reg[gi-1];
        assign id_next[gi]    = id_reg[gi-1];
      end
    end
  endgenerate

  assign relu_next = (CFG_RELU && SD_AXIS_TDATA[C_ACC_WIDTH-1]) ? '0 : SD_AXIS_TDATA;
  assign prod_next = PW'(relu_reg) * PW'($signed({1'b0, CFG_SCALE}));

`ifdef REQUANT_ROUND_EN
  assign round_bias = (CFG_SHIFT != 5'd0) ? (RW'(1) << (CFG_SHIFT - 5'd1)) : '0;
`else
  assign round_bias = '0;
`endif

  // One extra bit above the product so the rounding add cannot wrap.
  assign biased  = {prod_reg[PW-1], prod_reg} + round_bias;
  assign shifted = biased >>> CFG_SHIFT;
  assign summed  = {shifted[RW-1], shifted}
                 + {{(RW + 1 - C_OUT_WIDTH){CFG_ZERO_POINT[C_OUT_WIDTH-1]}}, CFG_ZERO_POINT};

  always_comb begin
    out_next = summed[C_OUT_WIDTH-1:0];
    if (summed > SAT_MAX) begin
      out_next = SAT_MAX[C_OUT_WIDTH-1:0];
    end else if (summed < SAT_MIN) begin
      out_next = SAT_MIN[C_OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      valid_reg <= '0;
      last_reg  <= '0;
      for (int i = 0; i < NS; i++) begin
        id_reg[i] <= '0;
      end
      relu_reg  <= '0;
      prod_reg  <= '0;
      out_reg   <= '0;
    end else if (en) begin
      valid_reg <= valid_next;
      last_reg  <= last_next;
      for (int i = 0; i < NS; i++) begin
        id_reg[i] <= id_next[i];
      end
      relu_reg  <= relu_next;
      prod_reg  <= prod_next;
      out_reg   <= out_next;
    end
  end

  assign MO_AXIS_TDATA  = out_reg;
  assign MO_AXIS_TVALID = valid_reg[NS-1];
  assign MO_AXIS_TLAST  = last_reg[NS-1];
  assign MO_AXIS_TID    = id_reg[NS-1];

endmodule

// File: tb/tb_mac_requant.sv
// Self-checking bench for mac_requant: directed steps plus a scoreboard queue checked by an output monitor.
module tb_mac_requant;

  logic        ACLK;
  logic        ARESETN;
  logic [15:0] CFG_SCALE;
  logic [4:0]  CFG_SHIFT;
  logic [7:0]  CFG_ZERO_POINT;
  logic        CFG_RELU;
  logic [31:0] SD_AXIS_TDATA;
  logic        SD_AXIS_TVALID;
  logic        SD_AXIS_TLAST;
  logic [7:0]  SD_AXIS_TID;
  logic        SD_AXIS_TREADY;
  logic [7:0]  MO_AXIS_TDATA;
  logic        MO_AXIS_TVALID;
  logic        MO_AXIS_TREADY;
  logic        MO_AXIS_TLAST;
  logic [7:0]  MO_AXIS_TID;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] id;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  mac_requant dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .CFG_SCALE      (CFG_SCALE),
    .CFG_SHIFT      (CFG_SHIFT),
    .CFG_ZERO_POINT (CFG_ZERO_POINT),
    .CFG_RELU       (CFG_RELU),
    .SD_AXIS_TDATA  (SD_AXIS_TDATA),
    .SD_AXIS_TVALID (SD_AXIS_TVALID),
    .SD_AXIS_TLAST  (SD_AXIS_TLAST),
    .SD_AXIS_TID    (SD_AXIS_TID),
    .SD_AXIS_TREADY (SD_AXIS_TREADY),
    .MO_AXIS_TDATA  (MO_AXIS_TDATA),
    .MO_AXIS_TVALID (MO_AXIS_TVALID),
    .MO_AXIS_TREADY (MO_AXIS_TREADY),
    .MO_AXIS_TLAST  (MO_AXIS_TLAST),
    .MO_AXIS_TID    (MO_AXIS_TID)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference arithmetic written directly from the requantization formula.
  function automatic logic [7:0] model(input longint acc, input longint scale, input int sh,
                                       input longint zp, input bit relu);
    longint r, p, q, s;
    r = (relu && acc < 0) ? 0 : acc;
    p = r * scale;
`ifdef REQUANT_ROUND_EN
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
    q = p >>> sh;
    s = q + zp;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return 8'(s);
  endfunction

  task automatic set_cfg(input int scale, input int sh, input int zp, input bit relu);
    CFG_SCALE      = 16'(scale);
    CFG_SHIFT      = 5'(sh);
    CFG_ZERO_POINT = 8'(zp);
    CFG_RELU       = relu;
  endtask

  // Drive one beat from posedge+1, wait for acceptance, push expectation.
  task automatic send(input int acc, input bit last, input logic [7:0] id,
                      input logic [7:0] expd, input bit track);
    bit ok;
    SD_AXIS_TDATA  = acc;
    SD_AXIS_TLAST  = last;
    SD_AXIS_TID    = id;
    SD_AXIS_TVALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge ACLK);
      ok = SD_AXIS_TREADY;
      @(posedge ACLK);
      #1;
    end
    SD_AXIS_TVALID = 1'b0;
    chk("input_accept", 32'(ok), 32'd1);
    if (track && ok) exp_q.push_back('{data: expd, last: last, id: id});
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge ACLK);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_latency(input string tag, input logic [7:0] expd);
    @(negedge ACLK);
    chk({tag, "_lat1"}, 32'(MO_AXIS_TVALID), 32'd0);
    @(negedge ACLK);
    chk({tag, "_lat2"}, 32'(MO_AXIS_TVALID), 32'd0);
    @(negedge ACLK);
    chk({tag, "_lat3_valid"}, 32'(MO_AXIS_TVALID), 32'd1);
    chk({tag, "_lat3_data"}, 32'(MO_AXIS_TDATA), 32'(expd));
  endtask

  // Output monitor: every handshake pops the scoreboard.
  always @(negedge ACLK) begin
    if (ARESETN && MO_AXIS_TVALID && MO_AXIS_TREADY) begin
      $display("out data=%0d last=%0d id=0x%02h", $signed(MO_AXIS_TDATA), MO_AXIS_TLAST, MO_AXIS_TID);
      chk("unexpected_output", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 32'(MO_AXIS_TDATA), 32'(e.data));
        chk("out_last", 32'(MO_AXIS_TLAST), 32'(e.last));
        chk("out_id", 32'(MO_AXIS_TID), 32'(e.id));
      end
    end
  end

  initial begin
    logic [7:0] held;
    bit seen;
    ARESETN = 1'b0;
    MO_AXIS_TREADY = 1'b1;
    SD_AXIS_TVALID = 1'b0;
    SD_AXIS_TDATA = '0;
    SD_AXIS_TLAST = 1'b0;
    SD_AXIS_TID = '0;
    set_cfg(1, 0, 0, 0);
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_tvalid", 32'(MO_AXIS_TVALID), 32'd0);
    chk("rst_tdata", 32'(MO_AXIS_TDATA), 32'd0);
    chk("rst_tlast", 32'(MO_AXIS_TLAST), 32'd0);
    chk("rst_tid", 32'(MO_AXIS_TID), 32'd0);
    chk("rst_tready", 32'(SD_AXIS_TREADY), 32'd0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_tready", 32'(SD_AXIS_TREADY), 32'd1);
    @(posedge ACLK);
    #1;

    // Basic scale/shift with latency check.
    set_cfg(1, 3, 0, 0);
`ifdef REQUANT_ROUND_EN
    send(1004, 1'b1, 8'h11, 8'd126, 1'b1);
    check_latency("basic", 8'd126);
`else
    send(1004, 1'b1, 8'h11, 8'd125, 1'b1);
    check_latency("basic", 8'd125);
`endif
    drain();

    // Saturation at both rails and with a zero point.
    set_cfg(1, 0, 0, 0);
    send(100000, 1'b0, 8'h21, 8'h7f, 1'b1);
    send(-100000, 1'b1, 8'h22, 8'h80, 1'b1);
    drain();
    set_cfg(1, 0, 5, 0);
    send(-128, 1'b1, 8'h23, 8'h85, 1'b1);
    drain();

    // ReLU with negative zero point.
    set_cfg(3, 1, -10, 1);
    send(-500, 1'b0, 8'h31, 8'hf6, 1'b1);
`ifdef REQUANT_ROUND_EN
    send(7, 1'b1, 8'h32, 8'h01, 1'b1);
`else
    send(7, 1'b1, 8'h32, 8'h00, 1'b1);
`endif
    drain();
    set_cfg(0, 4, 200, 0);
    send(123456, 1'b1, 8'h33, 8'hc8, 1'b1);
    drain();

    // Back-to-back stream with a 4-cycle stall after the first output.
    set_cfg(1, 0, 0, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, i == 7, 8'h2a, 8'(i), 1'b1);
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge ACLK);
          seen = MO_AXIS_TVALID;
        end
        chk("stream_first_out", 32'(seen), 32'd1);
        @(posedge ACLK);
        #1 MO_AXIS_TREADY = 1'b0;
        @(negedge ACLK);
        held = MO_AXIS_TDATA;
        chk("stall_tready", 32'(SD_AXIS_TREADY), 32'd0);
        chk("stall_valid", 32'(MO_AXIS_TVALID), 32'd1);
        chk("stall_data_first", 32'(held), 32'd1);
        for (int k = 0; k < 3; k++) begin
          @(negedge ACLK);
          chk("stall_tready", 32'(SD_AXIS_TREADY), 32'd0);
          chk("stall_data_stable", 32'(MO_AXIS_TDATA), 32'(held));
        end
        @(posedge ACLK);
        #1 MO_AXIS_TREADY = 1'b1;
      end
    join
    drain();

    // Model-checked random configs under random backpressure.
    for (int c = 0; c < 4; c++) begin
      int sc, sh, zp;
      bit rl;
      sc = int'($urandom_range(0, 65535));
      sh = int'($urandom_range(0, 31));
      zp = int'($signed(8'($urandom_range(0, 255))));
      rl = 1'($urandom_range(0, 1));
      set_cfg(sc, sh, zp, rl);
      fork
        begin
          for (int i = 0; i < 6; i++) begin
            int a;
            logic [7:0] idv;
            a = int'($urandom);
            if (i == 0) a = -a;
            idv = 8'($urandom_range(0, 255));
            send(a, i == 5, idv, model(longint'(a), longint'(sc), sh, longint'(zp), rl), 1'b1);
          end
        end
        begin
          repeat (12) begin
            @(posedge ACLK);
            #1 MO_AXIS_TREADY = 1'($urandom_range(0, 1));
          end
          MO_AXIS_TREADY = 1'b1;
        end
      join
      drain();
    end

    // Reset with three beats in flight and the output stalled.
    set_cfg(1, 0, 0, 0);
    MO_AXIS_TREADY = 1'b0;
    send(50, 1'b0, 8'h51, 8'd50, 1'b0);
    send(51, 1'b0, 8'h52, 8'd51, 1'b0);
    send(52, 1'b1, 8'h53, 8'd52, 1'b0);
    ARESETN = 1'b0;
    @(negedge ACLK);
    chk("midrst_tready", 32'(SD_AXIS_TREADY), 32'd0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;
    MO_AXIS_TREADY = 1'b1;
    @(negedge ACLK);
    chk("midrst_after_tvalid", 32'(MO_AXIS_TVALID), 32'd0);
    chk("midrst_after_tready", 32'(SD_AXIS_TREADY), 32'd1);
    repeat (6) @(posedge ACLK);
    #1;
    set_cfg(1, 2, 0, 0);
    send(16, 1'b1, 8'h54, 8'd4, 1'b1);
    check_latency("fresh", 8'd4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
